pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage MIPS-style cpu core (IF, ID, EXE, MEM, WB).
- Produces per-stage register enables and flush (bubble) strobes.
- Detects load-use hazards (load in ID/EXE, consumer in IF/ID) and inserts STALL_CYC bubble cycles.
- Squashes the three younger instructions when a branch or jump resolves taken in MEM.
- Keeps saturating performance counters for stall cycles and redirect events.

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline hazard controller and the CPU datapath.
// The datapath side is the master; the controller is the slave.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic             cnt_clr;
   logic [4:0]       if_id_rs;
   logic [4:0]       if_id_rt;
   logic             if_id_uses_rt;
   logic             id_ex_mem_read;
   logic [4:0]       id_ex_waddr;
   logic             mem_branch;
   logic             mem_zero;
   logic             mem_jump;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redir_cnt;

   modport master (
      output enable, cnt_clr, if_id_rs, if_id_rt, if_id_uses_rt,
             id_ex_mem_read, id_ex_waddr, mem_branch, mem_zero, mem_jump,
      input  pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
             ex_mem_flush, state, stall_cnt, redir_cnt
   );

   modport slave (
      input  enable, cnt_clr, if_id_rs, if_id_rt, if_id_uses_rt,
             id_ex_mem_read, id_ex_waddr, mem_branch, mem_zero, mem_jump,
      output pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush,
             ex_mem_flush, state, stall_cnt, redir_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, taken-branch/jump squashes,
// and saturating stall/redirect performance counters.
module pipeline_hazard_ctrl #(
   parameter int STALL_CYC = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int BUB_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [BUB_W-1:0] bub_q, bub_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

   logic redirect;
   logic hazard;
   logic do_run;
   logic do_stall;
   logic do_redir;

   assign redirect = bus.mem_jump | (bus.mem_branch & bus.mem_zero);

   // A load into $zero never produces a value, so it cannot create a hazard.
   assign hazard = bus.id_ex_mem_read && (bus.id_ex_waddr != 5'd0) &&
                   ((bus.id_ex_waddr == bus.if_id_rs) ||
                    (bus.if_id_uses_rt && (bus.id_ex_waddr == bus.if_id_rt)));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d  = state_q;
      bub_d    = bub_q;
      do_run   = 1'b0;
      do_stall = 1'b0;
      do_redir = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.enable) state_d = RUN;
         end
         RUN: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else if (redirect) begin
               do_redir = 1'b1;
            end else if (hazard) begin
               do_stall = 1'b1;
               if (STALL_CYC > 1) begin
                  state_d = STALL;
                  bub_d   = BUB_W'(STALL_CYC - 1);
               end
            end else begin
               do_run = 1'b1;
            end
         end
         STALL: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else if (redirect) begin
               // The squashed consumer no longer needs the remaining bubbles.
               do_redir = 1'b1;
               bub_d    = '0;
               state_d  = RUN;
            end else begin
               do_stall = 1'b1;
               bub_d    = bub_q - BUB_W'(1);
               if (bub_q == BUB_W'(1)) state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (bus.cnt_clr) begin
         stall_cnt_d = '0;
         redir_cnt_d = '0;
      end else begin
         if (do_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (do_redir && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= IDLE;
         bub_q       <= '0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         bub_q       <= bub_d;
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign bus.pc_en        = do_run | do_redir;
   assign bus.if_id_en     = do_run | do_redir;
   assign bus.id_ex_en     = do_run | do_redir | do_stall;
   assign bus.if_id_flush  = do_redir;
   assign bus.id_ex_flush  = do_redir | do_stall;
   assign bus.ex_mem_flush = do_redir;
   assign bus.state        = state_q;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.redir_cnt    = redir_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with a single-cycle
// stall and 16-bit counters, one with a three-cycle stall and 4-bit counters.
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic arst;
   int   n_assert = 0;
   int   n_fail   = 0;

   // Packed as {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush}.
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_RUN   = 6'b111000;
   localparam logic [5:0] O_STALL = 6'b001010;
   localparam logic [5:0] O_REDIR = 6'b111111;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) b1 ();
   pipeline_hazard_ctrl_if #(.CNT_W(4))  b3 ();

   pipeline_hazard_ctrl #(.STALL_CYC(1), .CNT_W(16)) u1 (
      .clk  (clk),
      .arst (arst),
      .bus  (b1.slave)
   );

   pipeline_hazard_ctrl #(.STALL_CYC(3), .CNT_W(4)) u3 (
      .clk  (clk),
      .arst (arst),
      .bus  (b3.slave)
   );

   wire [5:0] o1 = {b1.pc_en, b1.if_id_en, b1.id_ex_en, b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush};
   wire [5:0] o3 = {b3.pc_en, b3.if_id_en, b3.id_ex_en, b3.if_id_flush, b3.id_ex_flush, b3.ex_mem_flush};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      b1.enable = 0; b1.cnt_clr = 0; b1.if_id_rs = 0; b1.if_id_rt = 0; b1.if_id_uses_rt = 0;
      b1.id_ex_mem_read = 0; b1.id_ex_waddr = 0; b1.mem_branch = 0; b1.mem_zero = 0; b1.mem_jump = 0;
      b3.enable = 0; b3.cnt_clr = 0; b3.if_id_rs = 0; b3.if_id_rt = 0; b3.if_id_uses_rt = 0;
      b3.id_ex_mem_read = 0; b3.id_ex_waddr = 0; b3.mem_branch = 0; b3.mem_zero = 0; b3.mem_jump = 0;
   endtask

   task automatic test_reset();
      n_assert++; if (b1.state !== 2'd0) begin n_fail++; $display("FAIL reset_state1: got %0d expected 0", b1.state); end
      n_assert++; if (o1 !== O_IDLE) begin n_fail++; $display("FAIL reset_outs1: got %b expected %b", o1, O_IDLE); end
      n_assert++; if (b1.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt1: got %0d expected 0", b1.stall_cnt); end
      n_assert++; if (b1.redir_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_redir_cnt1: got %0d expected 0", b1.redir_cnt); end
      n_assert++; if (b3.state !== 2'd0) begin n_fail++; $display("FAIL reset_state3: got %0d expected 0", b3.state); end
      n_assert++; if (o3 !== O_IDLE) begin n_fail++; $display("FAIL reset_outs3: got %b expected %b", o3, O_IDLE); end
   endtask

   task automatic test_idle_to_run();
      b1.enable = 1; #1;
      n_assert++; if (o1 !== O_IDLE) begin n_fail++; $display("FAIL idle_outs: got %b expected %b", o1, O_IDLE); end
      n_assert++; if (b1.state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d expected 0", b1.state); end
      tick();
      n_assert++; if (b1.state !== 2'd1) begin n_fail++; $display("FAIL run_state: got %0d expected 1", b1.state); end
      n_assert++; if (o1 !== O_RUN) begin n_fail++; $display("FAIL run_outs: got %b expected %b", o1, O_RUN); end
   endtask

   task automatic test_load_use();
      b1.id_ex_mem_read = 1; b1.id_ex_waddr = 8; b1.if_id_rs = 8; #1;
      n_assert++; if (o1 !== O_STALL) begin n_fail++; $display("FAIL rs_hazard_outs: got %b expected %b", o1, O_STALL); end
      tick();
      n_assert++; if (b1.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rs_hazard_cnt: got %0d expected 1", b1.stall_cnt); end
      n_assert++; if (b1.state !== 2'd1) begin n_fail++; $display("FAIL rs_hazard_state: got %0d expected 1", b1.state); end
      b1.id_ex_mem_read = 0; #1;
      n_assert++; if (o1 !== O_RUN) begin n_fail++; $display("FAIL rs_hazard_release: got %b expected %b", o1, O_RUN); end
      b1.if_id_rs = 3; b1.if_id_rt = 8; b1.if_id_uses_rt = 0; b1.id_ex_mem_read = 1; #1;
      n_assert++; if (o1 !== O_RUN) begin n_fail++; $display("FAIL rt_unused_outs: got %b expected %b", o1, O_RUN); end
      tick();
      n_assert++; if (b1.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rt_unused_cnt: got %0d expected 1", b1.stall_cnt); end
      b1.if_id_uses_rt = 1; #1;
      n_assert++; if (o1 !== O_STALL) begin n_fail++; $display("FAIL rt_hazard_outs: got %b expected %b", o1, O_STALL); end
      tick();
      n_assert++; if (b1.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL rt_hazard_cnt: got %0d expected 2", b1.stall_cnt); end
      b1.id_ex_mem_read = 0; b1.if_id_uses_rt = 0; b1.if_id_rt = 0; b1.if_id_rs = 0;
   endtask

   task automatic test_zero_reg();
      b1.id_ex_mem_read = 1; b1.id_ex_waddr = 0; b1.if_id_rs = 0; #1;
      n_assert++; if (o1 !== O_RUN) begin n_fail++; $display("FAIL zero_reg_outs: got %b expected %b", o1, O_RUN); end
      tick();
      n_assert++; if (b1.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL zero_reg_cnt: got %0d expected 2", b1.stall_cnt); end
      b1.id_ex_mem_read = 0;
   endtask

   task automatic test_branch();
      b1.id_ex_mem_read = 1; b1.id_ex_waddr = 8; b1.if_id_rs = 8; b1.mem_branch = 1; b1.mem_zero = 1; #1;
      n_assert++; if (o1 !== O_REDIR) begin n_fail++; $display("FAIL branch_hz_outs: got %b expected %b", o1, O_REDIR); end
      tick();
      n_assert++; if (b1.redir_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_redir_cnt: got %0d expected 1", b1.redir_cnt); end
      n_assert++; if (b1.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL branch_stall_cnt: got %0d expected 2", b1.stall_cnt); end
      n_assert++; if (b1.state !== 2'd1) begin n_fail++; $display("FAIL branch_state: got %0d expected 1", b1.state); end
      b1.id_ex_mem_read = 0; b1.mem_zero = 0; #1;
      n_assert++; if (o1 !== O_RUN) begin n_fail++; $display("FAIL branch_not_taken_outs: got %b expected %b", o1, O_RUN); end
      tick();
      n_assert++; if (b1.redir_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_not_taken_cnt: got %0d expected 1", b1.redir_cnt); end
      b1.mem_branch = 0; b1.mem_jump = 1; #1;
      n_assert++; if (o1 !== O_REDIR) begin n_fail++; $display("FAIL jump_outs: got %b expected %b", o1, O_REDIR); end
      tick();
      n_assert++; if (b1.redir_cnt !== 16'd2) begin n_fail++; $display("FAIL jump_cnt: got %0d expected 2", b1.redir_cnt); end
      b1.mem_jump = 0;
   endtask

   task automatic test_freeze();
      b1.enable = 0; b1.mem_jump = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_assert++; if (o1 !== O_IDLE) begin n_fail++; $display("FAIL freeze_outs[%0d]: got %b expected %b", i, o1, O_IDLE); end
         tick();
      end
      n_assert++; if (b1.state !== 2'd0) begin n_fail++; $display("FAIL freeze_state: got %0d expected 0", b1.state); end
      n_assert++; if (b1.stall_cnt !== 16'd2) begin n_fail++; $display("FAIL freeze_stall_cnt: got %0d expected 2", b1.stall_cnt); end
      n_assert++; if (b1.redir_cnt !== 16'd2) begin n_fail++; $display("FAIL freeze_redir_cnt: got %0d expected 2", b1.redir_cnt); end
      b1.enable = 1; b1.mem_jump = 0; #1;
      n_assert++; if (o1 !== O_IDLE) begin n_fail++; $display("FAIL resume_idle_outs: got %b expected %b", o1, O_IDLE); end
      tick();
      n_assert++; if (b1.state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d expected 1", b1.state); end
      n_assert++; if (o1 !== O_RUN) begin n_fail++; $display("FAIL resume_outs: got %b expected %b", o1, O_RUN); end
   endtask

   task automatic test_cnt_clr();
      b1.cnt_clr = 1; b1.mem_jump = 1; #1;
      n_assert++; if (o1 !== O_REDIR) begin n_fail++; $display("FAIL clr_redir_outs: got %b expected %b", o1, O_REDIR); end
      tick();
      n_assert++; if (b1.redir_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_redir_cnt: got %0d expected 0", b1.redir_cnt); end
      n_assert++; if (b1.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_stall_cnt: got %0d expected 0", b1.stall_cnt); end
      b1.cnt_clr = 0; b1.mem_jump = 0;
   endtask

   task automatic test_multi_stall();
      b3.enable = 1; tick();
      n_assert++; if (b3.state !== 2'd1) begin n_fail++; $display("FAIL ms_run_state: got %0d expected 1", b3.state); end
      b3.id_ex_mem_read = 1; b3.id_ex_waddr = 5; b3.if_id_rs = 5; #1;
      n_assert++; if (o3 !== O_STALL) begin n_fail++; $display("FAIL ms_cyc1_outs: got %b expected %b", o3, O_STALL); end
      tick();
      n_assert++; if (b3.state !== 2'd2) begin n_fail++; $display("FAIL ms_cyc2_state: got %0d expected 2", b3.state); end
      n_assert++; if (b3.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL ms_cyc2_cnt: got %0d expected 1", b3.stall_cnt); end
      n_assert++; if (o3 !== O_STALL) begin n_fail++; $display("FAIL ms_cyc2_outs: got %b expected %b", o3, O_STALL); end
      tick();
      n_assert++; if (b3.state !== 2'd2) begin n_fail++; $display("FAIL ms_cyc3_state: got %0d expected 2", b3.state); end
      n_assert++; if (b3.stall_cnt !== 4'd2) begin n_fail++; $display("FAIL ms_cyc3_cnt: got %0d expected 2", b3.stall_cnt); end
      tick();
      n_assert++; if (b3.state !== 2'd1) begin n_fail++; $display("FAIL ms_done_state: got %0d expected 1", b3.state); end
      n_assert++; if (b3.stall_cnt !== 4'd3) begin n_fail++; $display("FAIL ms_done_cnt: got %0d expected 3", b3.stall_cnt); end
      b3.id_ex_mem_read = 0; #1;
      n_assert++; if (o3 !== O_RUN) begin n_fail++; $display("FAIL ms_done_outs: got %b expected %b", o3, O_RUN); end
   endtask

   task automatic test_stall_abort();
      b3.cnt_clr = 1; tick(); b3.cnt_clr = 0;
      n_assert++; if (b3.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL ab_clr_cnt: got %0d expected 0", b3.stall_cnt); end
      b3.id_ex_mem_read = 1; tick();
      n_assert++; if (b3.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL ab_cyc2_cnt: got %0d expected 1", b3.stall_cnt); end
      tick();
      n_assert++; if (b3.state !== 2'd2) begin n_fail++; $display("FAIL ab_cyc3_state: got %0d expected 2", b3.state); end
      b3.mem_jump = 1; #1;
      n_assert++; if (o3 !== O_REDIR) begin n_fail++; $display("FAIL ab_outs: got %b expected %b", o3, O_REDIR); end
      tick();
      n_assert++; if (b3.state !== 2'd1) begin n_fail++; $display("FAIL ab_state: got %0d expected 1", b3.state); end
      n_assert++; if (b3.redir_cnt !== 4'd1) begin n_fail++; $display("FAIL ab_redir_cnt: got %0d expected 1", b3.redir_cnt); end
      n_assert++; if (b3.stall_cnt !== 4'd2) begin n_fail++; $display("FAIL ab_stall_cnt: got %0d expected 2", b3.stall_cnt); end
      b3.mem_jump = 0; b3.id_ex_mem_read = 0; #1;
      n_assert++; if (o3 !== O_RUN) begin n_fail++; $display("FAIL ab_after_outs: got %b expected %b", o3, O_RUN); end
      // Abort on the first STALL cycle, while two bubbles are still owed.
      b3.id_ex_mem_read = 1; tick();
      n_assert++; if (b3.state !== 2'd2) begin n_fail++; $display("FAIL early_ab_pre_state: got %0d expected 2", b3.state); end
      b3.mem_jump = 1; #1;
      n_assert++; if (o3 !== O_REDIR) begin n_fail++; $display("FAIL early_ab_outs: got %b expected %b", o3, O_REDIR); end
      tick();
      n_assert++; if (b3.state !== 2'd1) begin n_fail++; $display("FAIL early_ab_state: got %0d expected 1", b3.state); end
      n_assert++; if (b3.stall_cnt !== 4'd3) begin n_fail++; $display("FAIL early_ab_stall_cnt: got %0d expected 3", b3.stall_cnt); end
      n_assert++; if (b3.redir_cnt !== 4'd2) begin n_fail++; $display("FAIL early_ab_redir_cnt: got %0d expected 2", b3.redir_cnt); end
      b3.mem_jump = 0; b3.id_ex_mem_read = 0; #1;
      n_assert++; if (o3 !== O_RUN) begin n_fail++; $display("FAIL early_ab_after_outs: got %b expected %b", o3, O_RUN); end
   endtask

   task automatic test_saturation();
      b3.mem_jump = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 12) begin
            n_assert++; if (b3.redir_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d expected 15", b3.redir_cnt); end
         end
      end
      n_assert++; if (b3.redir_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", b3.redir_cnt); end
      n_assert++; if (b3.stall_cnt !== 4'd3) begin n_fail++; $display("FAIL sat_stall_hold: got %0d expected 3", b3.stall_cnt); end
      b3.cnt_clr = 1; tick();
      n_assert++; if (b3.redir_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_redir: got %0d expected 0", b3.redir_cnt); end
      n_assert++; if (b3.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_stall: got %0d expected 0", b3.stall_cnt); end
      b3.cnt_clr = 0; tick();
      n_assert++; if (b3.redir_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_recount: got %0d expected 1", b3.redir_cnt); end
      b3.mem_jump = 0;
   endtask

   task automatic test_reset_mid_stall();
      b3.id_ex_mem_read = 1; b3.id_ex_waddr = 5; b3.if_id_rs = 5; tick();
      n_assert++; if (b3.state !== 2'd2) begin n_fail++; $display("FAIL rst_pre_state: got %0d expected 2", b3.state); end
      n_assert++; if (b3.stall_cnt !== 4'd1) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d expected 1", b3.stall_cnt); end
      #1 arst = 1;
      #1;
      n_assert++; if (b3.state !== 2'd0) begin n_fail++; $display("FAIL rst_async_state: got %0d expected 0", b3.state); end
      n_assert++; if (o3 !== O_IDLE) begin n_fail++; $display("FAIL rst_async_outs: got %b expected %b", o3, O_IDLE); end
      n_assert++; if (b3.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_async_stall_cnt: got %0d expected 0", b3.stall_cnt); end
      n_assert++; if (b3.redir_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_async_redir_cnt: got %0d expected 0", b3.redir_cnt); end
      n_assert++; if (b1.state !== 2'd0) begin n_fail++; $display("FAIL rst_async_state1: got %0d expected 0", b1.state); end
      arst = 0; b3.id_ex_mem_read = 0;
      tick();
      n_assert++; if (b3.state !== 2'd1) begin n_fail++; $display("FAIL rst_resume_state: got %0d expected 1", b3.state); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      arst = 1;
      clear_inputs();
      #2;
      test_reset();
      #10 arst = 0;
      tick();
      test_idle_to_run();
      test_load_use();
      test_zero_reg();
      test_branch();
      test_freeze();
      test_cnt_clr();
      test_multi_stall();
      test_stall_abort();
      test_saturation();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
